// File: rtl/bus_mem_port_if.sv
// Bundles the datapath-side and SRAM-side signals of the bus memory port.
// Latency: none, wires only.
// Backpressure: none; R is the only completion indication back to the datapath.
// Ports (slave = bus_mem_port):
//   in : BUS, LD_MAR, LD_MDR, MIO_EN, MEM_RD, MEM_WR, Data_from_SRAM
//   out: MAR, MDR, R, ADDR, Data_to_SRAM, Data_oe, CE_N, OE_N, WE_N, UB_N, LB_N
interface bus_mem_port_if #(
    parameter int ADDR_W = 20
);
    logic [15:0]       BUS;
    logic              LD_MAR;
    logic              LD_MDR;
    logic              MIO_EN;
    logic              MEM_RD;
    logic              MEM_WR;
    logic [15:0]       Data_from_SRAM;
    logic [15:0]       MAR;
    logic [15:0]       MDR;
    logic              R;
    logic [ADDR_W-1:0] ADDR;
    logic [15:0]       Data_to_SRAM;
    logic              Data_oe;
    logic              CE_N;
    logic              OE_N;
    logic              WE_N;
    logic              UB_N;
    logic              LB_N;

    modport slave (
        input  BUS, LD_MAR, LD_MDR, MIO_EN, MEM_RD, MEM_WR, Data_from_SRAM,
        output MAR, MDR, R, ADDR, Data_to_SRAM, Data_oe, CE_N, OE_N, WE_N, UB_N, LB_N
    );

    modport master (
        output BUS, LD_MAR, LD_MDR, MIO_EN, MEM_RD, MEM_WR, Data_from_SRAM,
        input  MAR, MDR, R, ADDR, Data_to_SRAM, Data_oe, CE_N, OE_N, WE_N, UB_N, LB_N
    );
endinterface

// File: rtl/bus_mem_port.sv
// MAR/MDR bus receiver plus fixed-wait-state SRAM read/write sequencer.
// Latency: request at edge k -> strobes cycles k+1..k+WAIT_CYCLES, R pulse in k+WAIT_CYCLES+1.
// Backpressure: none; requests outside IDLE are dropped, one IDLE cycle between accesses.
// Ports:
//   Clk, Reset : clock and synchronous active-high reset
//   io (slave) : datapath controls/BUS in, MAR/MDR/R out, SRAM address/data/strobes
module bus_mem_port #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic           Clk,
    input  logic           Reset,
    bus_mem_port_if.slave  io
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_DONE = 3'd2,
        WR_WAIT = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] rlat_q, rlat_d;
    // Snapshot of MAR/MDR taken when the request is accepted, so a same-cycle
    // LD_MAR/LD_MDR can update the architectural register without disturbing
    // the access that was just launched with the old value.
    logic [15:0] acc_addr_q, acc_addr_d;
    logic [15:0] wdat_q, wdat_d;
    logic        r_q, r_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        doe_q, doe_d;

    logic        ld_ok;
    logic        in_wait;
    logic [15:0] addr_mux;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mar_d      = mar_q;
        mdr_d      = mdr_q;
        rlat_d     = rlat_q;
        acc_addr_d = acc_addr_q;
        wdat_d     = wdat_q;

        // Register loads are only allowed while no SRAM access is in flight.
        ld_ok = (state_q == IDLE) || (state_q == RD_DONE) || (state_q == WR_DONE);
        if (ld_ok && io.LD_MAR) begin
            mar_d = io.BUS;
        end
        if (ld_ok && io.LD_MDR) begin
            mdr_d = io.MIO_EN ? rlat_q : io.BUS;
        end

        case (state_q)
            IDLE: begin
                if (io.MEM_RD) begin
                    // Read wins a simultaneous read/write; the write is lost.
                    state_d    = RD_WAIT;
                    cnt_d      = 4'd0;
                    acc_addr_d = mar_q;
                end else if (io.MEM_WR) begin
                    state_d    = WR_WAIT;
                    cnt_d      = 4'd0;
                    acc_addr_d = mar_q;
                    wdat_d     = mdr_q;
                end
            end
            RD_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    rlat_d  = io.Data_from_SRAM;
                    state_d = RD_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = WR_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Strobes and R are decoded from the next state so they come straight
        // off flops and line up exactly with the state they belong to.
        r_d    = (state_d == RD_DONE) || (state_d == WR_DONE);
        ce_n_d = !((state_d == RD_WAIT) || (state_d == WR_WAIT));
        oe_n_d = (state_d != RD_WAIT);
        we_n_d = (state_d != WR_WAIT);
        doe_d  = (state_d == WR_WAIT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            mar_q      <= 16'd0;
            mdr_q      <= 16'd0;
            rlat_q     <= 16'd0;
            acc_addr_q <= 16'd0;
            wdat_q     <= 16'd0;
            r_q        <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            doe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            rlat_q     <= rlat_d;
            acc_addr_q <= acc_addr_d;
            wdat_q     <= wdat_d;
            r_q        <= r_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            doe_q      <= doe_d;
        end
    end

    // ADDR follows MAR, except while strobes are active it holds the address
    // the access was launched with (MAR cannot change then anyway, apart from
    // the load that coincides with the request).
    assign in_wait  = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign addr_mux = in_wait ? acc_addr_q : mar_q;

    assign io.ADDR         = ADDR_W'(addr_mux);
    assign io.MAR          = mar_q;
    assign io.MDR          = mdr_q;
    assign io.R            = r_q;
    assign io.Data_to_SRAM = wdat_q;
    assign io.Data_oe      = doe_q;
    assign io.CE_N         = ce_n_q;
    assign io.OE_N         = oe_n_q;
    assign io.WE_N         = we_n_q;
    assign io.UB_N         = ce_n_q;
    assign io.LB_N         = ce_n_q;

endmodule

// File: tb/tb_bus_mem_port.sv
// Directed bench for bus_mem_port: cycle table on a WAIT_CYCLES=2 instance,
// hand sequences for reset abort and WAIT_CYCLES=1/15 timing.
// All three instances see identical stimulus.
module tb_bus_mem_port;

    logic        Clk;
    logic        Reset;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, mio_en, mem_rd, mem_wr;

    int n_tests = 0;
    int n_fail  = 0;

    bus_mem_port_if #(.ADDR_W(20)) i1 ();
    bus_mem_port_if #(.ADDR_W(20)) i2 ();
    bus_mem_port_if #(.ADDR_W(20)) i15 ();

    // SRAM contents: one fixed word, everything else derived from the address.
    function automatic logic [15:0] sram_rd(input logic [19:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return (a == 20'h03000) ? 16'hBEEF : (lo ^ 16'hA5A5);
    endfunction

    assign i1.BUS = bus;      assign i2.BUS = bus;      assign i15.BUS = bus;
    assign i1.LD_MAR = ld_mar; assign i2.LD_MAR = ld_mar; assign i15.LD_MAR = ld_mar;
    assign i1.LD_MDR = ld_mdr; assign i2.LD_MDR = ld_mdr; assign i15.LD_MDR = ld_mdr;
    assign i1.MIO_EN = mio_en; assign i2.MIO_EN = mio_en; assign i15.MIO_EN = mio_en;
    assign i1.MEM_RD = mem_rd; assign i2.MEM_RD = mem_rd; assign i15.MEM_RD = mem_rd;
    assign i1.MEM_WR = mem_wr; assign i2.MEM_WR = mem_wr; assign i15.MEM_WR = mem_wr;
    assign i1.Data_from_SRAM  = sram_rd(i1.ADDR);
    assign i2.Data_from_SRAM  = sram_rd(i2.ADDR);
    assign i15.Data_from_SRAM = sram_rd(i15.ADDR);

    bus_mem_port #(.WAIT_CYCLES(1),  .ADDR_W(20)) u1  (.Clk(Clk), .Reset(Reset), .io(i1.slave));
    bus_mem_port #(.WAIT_CYCLES(2),  .ADDR_W(20)) u2  (.Clk(Clk), .Reset(Reset), .io(i2.slave));
    bus_mem_port #(.WAIT_CYCLES(15), .ADDR_W(20)) u15 (.Clk(Clk), .Reset(Reset), .io(i15.slave));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] bus;
        logic        ld_mar, ld_mdr, mio, rd, wr;
        logic [15:0] e_mar, e_mdr;
        logic        e_r;
        logic [3:0]  e_strb;   // {CE_N, OE_N, WE_N, Data_oe}
        logic [15:0] e_addr;
        logic        chk_dto;
        logic [15:0] e_dto;
    } vec_t;

    localparam logic [3:0] S_IDL = 4'b1110;
    localparam logic [3:0] S_RD  = 4'b0010;
    localparam logic [3:0] S_WR  = 4'b0101;

    vec_t tbl [20];

    function automatic vec_t mk(input logic [15:0] b, input logic lm, input logic ld,
                                input logic mi, input logic rd, input logic wr,
                                input logic [15:0] emar, input logic [15:0] emdr,
                                input logic er, input logic [3:0] es,
                                input logic [15:0] ea, input logic cd, input logic [15:0] edto);
        vec_t v;
        v.bus = b; v.ld_mar = lm; v.ld_mdr = ld; v.mio = mi; v.rd = rd; v.wr = wr;
        v.e_mar = emar; v.e_mdr = emdr; v.e_r = er; v.e_strb = es;
        v.e_addr = ea; v.chk_dto = cd; v.e_dto = edto;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_in();
        bus = 16'h0; ld_mar = 0; ld_mdr = 0; mio_en = 0; mem_rd = 0; mem_wr = 0;
    endtask

    // Timing check for one instance at cycle t after the request edge.
    task automatic chk_tim(input string nm, input int w, input int t, input logic is_wr,
                           input logic ce, input logic oe, input logic we, input logic doe,
                           input logic r, input logic [15:0] dto);
        logic act;
        act = (t >= 1) && (t <= w);
        chk($sformatf("%s t%0d CE_N", nm, t), 32'(ce), 32'(!act));
        chk($sformatf("%s t%0d OE_N", nm, t), 32'(oe), 32'(is_wr ? 1'b1 : !act));
        chk($sformatf("%s t%0d WE_N", nm, t), 32'(we), 32'(is_wr ? !act : 1'b1));
        chk($sformatf("%s t%0d Data_oe", nm, t), 32'(doe), 32'(is_wr && act));
        chk($sformatf("%s t%0d R", nm, t), 32'(r), 32'(t == w + 1));
        if (is_wr && act) chk($sformatf("%s t%0d Data_to_SRAM", nm, t), 32'(dto), 32'h0000A5A5);
    endtask

    initial begin
        //             bus     lm ld mi rd wr | MAR     MDR     R  strb   ADDR    dto?  dto
        tbl[0]  = mk(16'h3000, 1, 0, 0, 0, 0, 16'h3000, 16'h0000, 0, S_IDL, 16'h3000, 0, 16'h0);
        tbl[1]  = mk(16'h0000, 0, 0, 0, 1, 0, 16'h3000, 16'h0000, 0, S_RD,  16'h3000, 0, 16'h0);
        tbl[2]  = mk(16'h5555, 0, 1, 0, 0, 0, 16'h3000, 16'h0000, 0, S_RD,  16'h3000, 0, 16'h0);
        tbl[3]  = mk(16'h0000, 0, 0, 0, 0, 0, 16'h3000, 16'h0000, 1, S_IDL, 16'h3000, 0, 16'h0);
        tbl[4]  = mk(16'h0000, 0, 1, 1, 0, 0, 16'h3000, 16'hBEEF, 0, S_IDL, 16'h3000, 0, 16'h0);
        tbl[5]  = mk(16'h0010, 1, 0, 0, 0, 0, 16'h0010, 16'hBEEF, 0, S_IDL, 16'h0010, 0, 16'h0);
        tbl[6]  = mk(16'h1234, 0, 1, 0, 0, 0, 16'h0010, 16'h1234, 0, S_IDL, 16'h0010, 0, 16'h0);
        tbl[7]  = mk(16'h0000, 0, 0, 0, 0, 1, 16'h0010, 16'h1234, 0, S_WR,  16'h0010, 1, 16'h1234);
        tbl[8]  = mk(16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h1234, 0, S_WR,  16'h0010, 1, 16'h1234);
        tbl[9]  = mk(16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h1234, 1, S_IDL, 16'h0010, 0, 16'h0);
        tbl[10] = mk(16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h1234, 0, S_IDL, 16'h0010, 0, 16'h0);
        // read+write together with LD_MAR: read of old MAR, MAR updates anyway
        tbl[11] = mk(16'h0040, 1, 0, 0, 1, 1, 16'h0040, 16'h1234, 0, S_RD,  16'h0010, 0, 16'h0);
        tbl[12] = mk(16'hFFFF, 1, 0, 0, 1, 0, 16'h0040, 16'h1234, 0, S_RD,  16'h0010, 0, 16'h0);
        tbl[13] = mk(16'hFFFF, 1, 0, 0, 0, 1, 16'h0040, 16'h1234, 1, S_IDL, 16'h0040, 0, 16'h0);
        tbl[14] = mk(16'hFFFF, 1, 1, 1, 0, 0, 16'hFFFF, 16'hA5B5, 0, S_IDL, 16'hFFFF, 0, 16'h0);
        tbl[15] = mk(16'h0000, 0, 0, 0, 0, 0, 16'hFFFF, 16'hA5B5, 0, S_IDL, 16'hFFFF, 0, 16'h0);
        // write with LD_MDR in the same cycle: old MDR goes to SRAM
        tbl[16] = mk(16'h7777, 0, 1, 0, 0, 1, 16'hFFFF, 16'h7777, 0, S_WR,  16'hFFFF, 1, 16'hA5B5);
        tbl[17] = mk(16'h0000, 0, 0, 0, 0, 0, 16'hFFFF, 16'h7777, 0, S_WR,  16'hFFFF, 1, 16'hA5B5);
        tbl[18] = mk(16'h0000, 0, 0, 0, 0, 0, 16'hFFFF, 16'h7777, 1, S_IDL, 16'hFFFF, 0, 16'h0);
        tbl[19] = mk(16'h0000, 0, 0, 0, 0, 0, 16'hFFFF, 16'h7777, 0, S_IDL, 16'hFFFF, 0, 16'h0);

        idle_in();
        Reset = 1'b1;
        step();
        step();
        chk("reset MAR", 32'(i2.MAR), 32'h0);
        chk("reset MDR", 32'(i2.MDR), 32'h0);
        chk("reset R", 32'(i2.R), 32'h0);
        chk("reset strobes", 32'({i2.CE_N, i2.OE_N, i2.WE_N, i2.Data_oe}), 32'(S_IDL));
        chk("reset UB/LB", 32'({i2.UB_N, i2.LB_N}), 32'h3);
        Reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            bus = tbl[i].bus; ld_mar = tbl[i].ld_mar; ld_mdr = tbl[i].ld_mdr;
            mio_en = tbl[i].mio; mem_rd = tbl[i].rd; mem_wr = tbl[i].wr;
            step();
            chk($sformatf("row%0d MAR", i), 32'(i2.MAR), 32'(tbl[i].e_mar));
            chk($sformatf("row%0d MDR", i), 32'(i2.MDR), 32'(tbl[i].e_mdr));
            chk($sformatf("row%0d R", i), 32'(i2.R), 32'(tbl[i].e_r));
            chk($sformatf("row%0d strobes", i),
                32'({i2.CE_N, i2.OE_N, i2.WE_N, i2.Data_oe}), 32'(tbl[i].e_strb));
            chk($sformatf("row%0d UB/LB", i), 32'({i2.UB_N, i2.LB_N}),
                32'({tbl[i].e_strb[3], tbl[i].e_strb[3]}));
            chk($sformatf("row%0d ADDR", i), 32'(i2.ADDR), 32'({4'h0, tbl[i].e_addr}));
            if (tbl[i].chk_dto)
                chk($sformatf("row%0d Data_to_SRAM", i), 32'(i2.Data_to_SRAM), 32'(tbl[i].e_dto));
        end
        idle_in();

        // Reset held two cycles in the middle of a write aborts it silently.
        mem_wr = 1'b1;
        step();
        mem_wr = 1'b0;
        chk("midwr WE_N low", 32'(i2.WE_N), 32'h0);
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        chk("abort strobes", 32'({i2.CE_N, i2.OE_N, i2.WE_N, i2.Data_oe}), 32'(S_IDL));
        chk("abort MAR", 32'(i2.MAR), 32'h0);
        chk("abort MDR", 32'(i2.MDR), 32'h0);
        chk("abort R", 32'(i2.R), 32'h0);
        mem_rd = 1'b1;
        step();
        mem_rd = 1'b0;
        chk("abort then IDLE accepts read", 32'({i2.CE_N, i2.OE_N, i2.WE_N}), 32'h1);

        // WAIT_CYCLES 1/2/15: read then write, same stimulus to all instances.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        mem_rd = 1'b1;
        step();
        mem_rd = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            chk_tim("rd w1", 1, t, 1'b0, i1.CE_N, i1.OE_N, i1.WE_N, i1.Data_oe, i1.R, i1.Data_to_SRAM);
            chk_tim("rd w2", 2, t, 1'b0, i2.CE_N, i2.OE_N, i2.WE_N, i2.Data_oe, i2.R, i2.Data_to_SRAM);
            chk_tim("rd w15", 15, t, 1'b0, i15.CE_N, i15.OE_N, i15.WE_N, i15.Data_oe, i15.R, i15.Data_to_SRAM);
            step();
        end
        ld_mdr = 1'b1;
        mio_en = 1'b1;
        step();
        idle_in();
        chk("w1 read data", 32'(i1.MDR), 32'h0000A5A5);
        chk("w2 read data", 32'(i2.MDR), 32'h0000A5A5);
        chk("w15 read data", 32'(i15.MDR), 32'h0000A5A5);

        mem_wr = 1'b1;
        step();
        mem_wr = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            chk_tim("wr w1", 1, t, 1'b1, i1.CE_N, i1.OE_N, i1.WE_N, i1.Data_oe, i1.R, i1.Data_to_SRAM);
            chk_tim("wr w2", 2, t, 1'b1, i2.CE_N, i2.OE_N, i2.WE_N, i2.Data_oe, i2.R, i2.Data_to_SRAM);
            chk_tim("wr w15", 15, t, 1'b1, i15.CE_N, i15.OE_N, i15.WE_N, i15.Data_oe, i15.R, i15.Data_to_SRAM);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
